elastic_pipe_reg: RTL
=====================

ELASTIC_PIPE_REG -- requirements
Module: elastic_pipe_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, payload width in bits (1..256).
REQ-002 The block SHALL have parameter SKID, default 1: 0 = single-entry stage; 1 = two-entry skid stage with registered in_ready.
REQ-003 The block SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 CLK  input  1  clock; every flop SHALL update on the rising edge.
REQ-005 RST  input  1  synchronous active-high reset, sampled on the rising edge of CLK.
REQ-006 in_valid  input  1  upstream entry offered.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 in_halt  input  1  upstream halt sideband.
REQ-009 in_ready  output  1  stage accepts an entry this cycle.
REQ-010 out_valid  output  1  head entry presented downstream.
REQ-011 out_data  output  WIDTH  head payload.
REQ-012 out_halt  output  1  head halt sideband.
REQ-013 out_ready  input  1  downstream accepts the head.
REQ-014 flush  input  1  discard all held entries and the incoming entry.
REQ-015 occupancy  output  2  entries held (0..1 when SKID=0, 0..2 when SKID=1).
REQ-016 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.
REQ-017 stall_clr  input  1  clear stall_cnt.

Function
REQ-018 Transfers SHALL occur: in on in_valid&in_ready, out on out_valid&out_ready, both on the same rising edge.
REQ-019 Latency SHALL be one cycle: an entry accepted at edge N is presented on out_* after edge N; no combinational in_data->out_data path.
REQ-020 Ordering SHALL be FIFO; entries SHALL not be dropped or duplicated outside flush.
REQ-021 SKID=0: in_ready SHALL equal (occupancy==0) | out_ready, combinationally.
REQ-022 SKID=1: in_ready SHALL be a flop output, 1 iff occupancy<2 after the current edge; out_ready SHALL not combinationally drive in_ready.
REQ-023 SKID=1 with occupancy 1 and simultaneous in and out transfer: occupancy SHALL stay 1 and the new entry SHALL become head.
REQ-024 Full (occupancy at maximum) with out_ready=0: in_ready=0 and held entries SHALL remain stable.
REQ-025 Empty: out_valid=0; out_data and out_halt SHALL be 0.
REQ-026 out_valid SHALL not deassert until its entry is transferred or flushed.
REQ-027 flush=1 SHALL set occupancy to 0 at the next edge and discard any out transfer that cycle.
REQ-028 Halt exception: flush=1 with in_valid=1 and in_halt=1 SHALL leave one entry after the edge, out_valid=1, out_halt=1, out_data=0.
REQ-029 flush has priority over in transfer; in_ready during flush SHALL still follow REQ-021/022 from pre-flush state.
REQ-030 stall_cnt SHALL increment by 1 each edge with out_valid=1 and out_ready=0 and flush=0, saturating at 2^CNT_W-1.
REQ-031 stall_clr=1 SHALL load stall_cnt with 0, overriding increment.
REQ-032 out_halt, once presented, SHALL follow normal handshake (no self-clearing).

Reset
REQ-033 RST=1 SHALL on the next edge force occupancy=0, out_valid=0, out_data=0, out_halt=0, stall_cnt=0.
REQ-034 RST SHALL override flush, stall_clr and all transfers; entries in flight SHALL be discarded.
REQ-035 SKID=1: in_ready SHALL be 0 while RST=1 and 1 at the first edge after RST deasserts.

Verification
REQ-036 Streaming: WIDTH=32, SKID=1, out_ready=1, in 0x1..0x8 back-to-back -> out 0x1..0x8 in order, each one cycle later, occupancy<=1, stall_cnt=0.
REQ-037 Backpressure: SKID=1, load 0xA,0xB, out_ready=0 for 5 cycles -> occupancy=2, in_ready=0, out_data=0xA stable, stall_cnt=5; release -> 0xA,0xB delivered.
REQ-038 Flush: occupancy=2, flush=1 with in_valid=1, in_halt=0 -> occupancy=0, out_valid=0 next cycle; repeated with in_halt=1 -> out_valid=1, out_halt=1, out_data=0.
REQ-039 Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15; stall_clr pulse -> 0.
REQ-040 Reset mid-operation: occupancy=2, stall_cnt=7, RST=1 one cycle -> all outputs 0; SKID=0 variant: in_ready=1 with out_ready=0 only when empty.

Source files
------------

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: one- or two-entry FIFO stage with a halt sideband and a stall counter.
// Latency: one cycle from an accepted in_* entry to out_*; no combinational in_data->out_data path.
// Backpressure: SKID=0 in_ready = empty | out_ready (comb); SKID=1 in_ready is a flop = "room after this edge".
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   in_valid/in_data/in_halt upstream entry; in_ready accepts it
//   out_valid/out_data/out_halt head entry; out_ready accepts it
//   flush                    drop everything held plus the incoming entry (halt exception keeps a marker)
//   occupancy                entries currently held
//   stall_cnt / stall_clr    saturating count of cycles the head waits on out_ready; synchronous clear
module elastic_pipe_reg #(
  parameter int WIDTH = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_halt,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_halt,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_clr
);

  // Slot 0 is always the head; slot 1 only holds an entry when occupancy is 2.
  logic [WIDTH-1:0] data_q [2];
  logic [WIDTH-1:0] data_d [2];
  logic [1:0]       halt_q, halt_d;
  logic [1:0]       occ_q, occ_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic push, pop;

  // Outputs are gated by occupancy so an empty stage presents all zeros
  // regardless of stale slot contents.
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = out_valid ? data_q[0] : '0;
  assign out_halt  = out_valid & halt_q[0];
  assign occupancy = occ_q;
  assign stall_cnt = cnt_q;

  // SKID=1: registered ready, forced low while reset is held so nothing is
  // accepted before the first post-reset edge has computed it.
  assign in_ready = (SKID != 0) ? (rdy_q & ~RST) : ((occ_q == 2'd0) | out_ready);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    occ_d  = occ_q;
    data_d = data_q;
    halt_d = halt_q;
    if (flush) begin
      // Flush wins over any transfer; a halting entry leaves a zero-payload
      // halt marker behind so downstream still sees the halt.
      occ_d = 2'd0;
      if (in_valid && in_halt) begin
        occ_d     = 2'd1;
        data_d[0] = '0;
        halt_d[0] = 1'b1;
      end
    end else begin
      case (occ_q)
        2'd0: begin
          if (push) begin
            data_d[0] = in_data;
            halt_d[0] = in_halt;
            occ_d     = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            // Head leaves, newcomer takes its place.
            data_d[0] = in_data;
            halt_d[0] = in_halt;
          end else if (pop) begin
            occ_d = 2'd0;
          end else if (push) begin
            data_d[1] = in_data;
            halt_d[1] = in_halt;
            occ_d     = 2'd2;
          end
        end
        default: begin
          // Full: in_ready is low, so only a pop can happen.
          if (pop) begin
            data_d[0] = data_q[1];
            halt_d[0] = halt_q[1];
            occ_d     = 2'd1;
          end
        end
      endcase
    end
  end

  assign rdy_d = (occ_d < 2'd2);

  always_comb begin
    cnt_d = cnt_q;
    if (stall_clr) begin
      cnt_d = '0;
    end else if (out_valid && !out_ready && !flush && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      occ_q  <= 2'd0;
      data_q <= '{default: '0};
      halt_q <= 2'b00;
      rdy_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      data_q <= data_d;
      halt_q <= halt_d;
      rdy_q  <= rdy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
